// File: rtl/fft_pkg.sv
// Shared FFT datapath parameters and sample/lane-vector types.
// Used by the pair buffer and by the butterfly stages that follow it.
package fft_pkg;
  localparam int DATA_W     = 10;
  localparam int LANES      = 16;
  localparam int FFT_N      = 512;
  localparam int HALF_BEATS = FFT_N / (2 * LANES);
  localparam int CNT_W      = $clog2(2 * HALF_BEATS);
  localparam int ADDR_W     = $clog2(HALF_BEATS);
  localparam int IDX_W      = $clog2(FFT_N);
  localparam int LANE_SH    = $clog2(LANES);

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef sample_t [LANES-1:0] lane_vec_t;

  typedef struct packed {
    lane_vec_t im;
    lane_vec_t re;
  } beat_t;
endpackage

// File: rtl/fft_beat_ram.sv
// Half-frame beat store: one write port, one combinational read port.
// Plain register array so it maps onto distributed RAM.
module fft_beat_ram
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  beat_t             wdata,
  input  logic [ADDR_W-1:0] raddr,
  output beat_t             rdata
);
  beat_t mem_q [HALF_BEATS];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fft_pair_buffer.sv
// Buffers the first half-frame and pairs each second-half beat with the beat
// 256 samples earlier, feeding the first radix-2 butterfly stage.
module fft_pair_buffer
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             valid_in,
  input  logic             sync_in,
  input  lane_vec_t        din_real,
  input  lane_vec_t        din_imag,
  output logic             valid_out,
  output logic [IDX_W-1:0] base_idx_out,
  output lane_vec_t        out_real_a,
  output lane_vec_t        out_imag_a,
  output lane_vec_t        out_real_b,
  output lane_vec_t        out_imag_b,
  output logic             sync_err
);
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              valid_out_q, valid_out_d;
  logic              sync_err_q, sync_err_d;
  logic [IDX_W-1:0]  base_idx_q, base_idx_d;
  beat_t             a_q, a_d, b_q, b_d;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  beat_t             ram_wdata, ram_rdata;

  assign ram_wdata.re = din_real;
  assign ram_wdata.im = din_imag;

  fft_beat_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (beat_cnt_q[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    valid_out_d = 1'b0;
    sync_err_d  = 1'b0;
    base_idx_d  = base_idx_q;
    a_d         = a_q;
    b_d         = b_q;
    ram_we      = 1'b0;
    ram_waddr   = beat_cnt_q[ADDR_W-1:0];
    if (valid_in) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
      if (sync_in && beat_cnt_q != '0) begin
        // Misplaced sync: abandon the partial frame and restart at beat 0.
        sync_err_d = 1'b1;
        ram_we     = 1'b1;
        ram_waddr  = '0;
        beat_cnt_d = CNT_W'(1);
      end else if (!beat_cnt_q[CNT_W-1]) begin
        ram_we = 1'b1;
      end else begin
        valid_out_d = 1'b1;
        base_idx_d  = IDX_W'({beat_cnt_q[ADDR_W-1:0], {LANE_SH{1'b0}}});
        a_d         = ram_rdata;
        b_d         = ram_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      beat_cnt_q  <= '0;
      valid_out_q <= 1'b0;
      sync_err_q  <= 1'b0;
      base_idx_q  <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      valid_out_q <= valid_out_d;
      sync_err_q  <= sync_err_d;
      base_idx_q  <= base_idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
    end
  end

  assign valid_out    = valid_out_q;
  assign sync_err     = sync_err_q;
  assign base_idx_out = base_idx_q;
  assign out_real_a   = a_q.re;
  assign out_imag_a   = a_q.im;
  assign out_real_b   = b_q.re;
  assign out_imag_b   = b_q.im;
endmodule

// File: tb/tb_fft_pair_buffer.sv
// Scoreboard bench for fft_pair_buffer: frames are held as 512-sample arrays
// and expected pairs are taken straight from sample n and n+256.
module tb_fft_pair_buffer;
  import fft_pkg::*;

  typedef struct packed {
    int               cyc;
    logic [IDX_W-1:0] base;
    lane_vec_t        ra;
    lane_vec_t        ia;
    lane_vec_t        rb;
    lane_vec_t        ib;
  } pair_t;

  logic             clk = 1'b0;
  logic             rstn;
  logic             valid_in;
  logic             sync_in;
  lane_vec_t        din_real, din_imag;
  logic             valid_out;
  logic [IDX_W-1:0] base_idx_out;
  lane_vec_t        out_real_a, out_imag_a, out_real_b, out_imag_b;
  logic             sync_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  sample_t fr_re [FFT_N];
  sample_t fr_im [FFT_N];
  pair_t   exp_q [$];
  pair_t   got_q [$];
  int      sync_q [$];

  fft_pair_buffer dut (
    .clk          (clk),
    .rstn         (rstn),
    .valid_in     (valid_in),
    .sync_in      (sync_in),
    .din_real     (din_real),
    .din_imag     (din_imag),
    .valid_out    (valid_out),
    .base_idx_out (base_idx_out),
    .out_real_a   (out_real_a),
    .out_imag_a   (out_imag_a),
    .out_real_b   (out_real_b),
    .out_imag_b   (out_imag_b),
    .sync_err     (sync_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    pair_t p;
    if (valid_out === 1'b1) begin
      p.cyc  = cyc;
      p.base = base_idx_out;
      p.ra   = out_real_a;
      p.ia   = out_imag_a;
      p.rb   = out_real_b;
      p.ib   = out_imag_b;
      got_q.push_back(p);
    end
    if (sync_err === 1'b1) sync_q.push_back(cyc);
  end

  task automatic gen_random();
    for (int n = 0; n < FFT_N; n++) begin
      fr_re[n] = sample_t'($urandom);
      fr_im[n] = sample_t'($urandom);
    end
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
    sync_q.delete();
  endtask

  // Drives beats first..last of the current frame arrays; optional random gaps.
  task automatic drive_frame(input int first, input int last, input bit sync0, input int gap_max);
    pair_t p;
    for (int k = first; k <= last; k++) begin
      if (gap_max > 0 && $urandom_range(0, 99) < 40) begin
        repeat ($urandom_range(1, gap_max)) begin
          valid_in = 1'b0;
          sync_in  = 1'($urandom);
          din_real = lane_vec_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
          din_imag = lane_vec_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
          @(negedge clk);
        end
      end
      valid_in = 1'b1;
      sync_in  = (k == 0) && sync0;
      for (int j = 0; j < LANES; j++) begin
        din_real[j] = fr_re[LANES*k + j];
        din_imag[j] = fr_im[LANES*k + j];
      end
      if (k >= HALF_BEATS) begin
        p.cyc  = cyc + 1;
        p.base = IDX_W'((k - HALF_BEATS) * LANES);
        for (int j = 0; j < LANES; j++) begin
          p.ra[j] = fr_re[(k - HALF_BEATS)*LANES + j];
          p.ia[j] = fr_im[(k - HALF_BEATS)*LANES + j];
          p.rb[j] = fr_re[(k - HALF_BEATS)*LANES + j + FFT_N/2];
          p.ib[j] = fr_im[(k - HALF_BEATS)*LANES + j + FFT_N/2];
        end
        exp_q.push_back(p);
      end
      @(negedge clk);
    end
    valid_in = 1'b0;
    sync_in  = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (valid_out !== 1'b0 || sync_err !== 1'b0 || base_idx_out !== '0) begin
      bad++;
      $display("FAIL reset_ctrl got v=%b se=%b base=%0d need 0/0/0", valid_out, sync_err, base_idx_out);
    end
    total++;
    if ({out_real_a, out_imag_a, out_real_b, out_imag_b} !== '0) begin
      bad++;
      $display("FAIL reset_data got ra=%h rb=%h need 0", out_real_a, out_real_b);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ramp();
    clear_q();
    for (int n = 0; n < FFT_N; n++) begin
      fr_re[n] = sample_t'(n - 256);
      fr_im[n] = sample_t'(256 - n);
    end
    drive_frame(0, 31, 1'b1, 0);
    repeat (4) @(negedge clk);
    total++;
    if (got_q.size() != 16 || exp_q.size() != 16) begin
      bad++;
      $display("FAIL ramp_count got=%0d need=16", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL ramp_pair%0d got cyc=%0d base=%0d ra=%h rb=%h need cyc=%0d base=%0d ra=%h rb=%h",
                 i, got_q[i].cyc, got_q[i].base, got_q[i].ra, got_q[i].rb,
                 exp_q[i].cyc, exp_q[i].base, exp_q[i].ra, exp_q[i].rb);
      end
    end
    total++;
    if (sync_q.size() != 0) begin
      bad++;
      $display("FAIL ramp_sync_err got=%0d pulses need=0", sync_q.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    for (int f = 0; f < 3; f++) begin
      gen_random();
      drive_frame(0, 31, f == 0, 0);
    end
    repeat (4) @(negedge clk);
    total++;
    if (got_q.size() != 48) begin
      bad++;
      $display("FAIL b2b_count got=%0d need=48", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_pair%0d got cyc=%0d base=%0d ra=%h rb=%h need cyc=%0d base=%0d ra=%h rb=%h",
                 i, got_q[i].cyc, got_q[i].base, got_q[i].ra, got_q[i].rb,
                 exp_q[i].cyc, exp_q[i].base, exp_q[i].ra, exp_q[i].rb);
      end
    end
  endtask

  task automatic test_gaps();
    clear_q();
    for (int f = 0; f < 2; f++) begin
      gen_random();
      drive_frame(0, 31, 1'b0, 7);
    end
    repeat (4) @(negedge clk);
    total++;
    if (got_q.size() != 32) begin
      bad++;
      $display("FAIL gaps_count got=%0d need=32", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL gaps_pair%0d got cyc=%0d base=%0d ra=%h ib=%h need cyc=%0d base=%0d ra=%h ib=%h",
                 i, got_q[i].cyc, got_q[i].base, got_q[i].ra, got_q[i].ib,
                 exp_q[i].cyc, exp_q[i].base, exp_q[i].ra, exp_q[i].ib);
      end
    end
    total++;
    if (sync_q.size() != 0) begin
      bad++;
      $display("FAIL gaps_sync_err got=%0d pulses need=0", sync_q.size());
    end
  endtask

  task automatic test_sync();
    int sync_exp;
    clear_q();
    gen_random();
    drive_frame(0, 19, 1'b1, 0);
    gen_random();
    sync_exp = cyc + 1;
    drive_frame(0, 31, 1'b1, 0);
    repeat (4) @(negedge clk);
    total++;
    if (sync_q.size() != 1 || (sync_q.size() == 1 && sync_q[0] != sync_exp)) begin
      bad++;
      $display("FAIL sync_pulse got n=%0d first=%0d need n=1 at %0d",
               sync_q.size(), (sync_q.size() > 0) ? sync_q[0] : -1, sync_exp);
    end
    total++;
    if (got_q.size() != 20) begin
      bad++;
      $display("FAIL sync_count got=%0d need=20", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL sync_pair%0d got cyc=%0d base=%0d ra=%h rb=%h need cyc=%0d base=%0d ra=%h rb=%h",
                 i, got_q[i].cyc, got_q[i].base, got_q[i].ra, got_q[i].rb,
                 exp_q[i].cyc, exp_q[i].base, exp_q[i].ra, exp_q[i].rb);
      end
    end
  endtask

  task automatic test_reset_midframe();
    clear_q();
    gen_random();
    drive_frame(0, 23, 1'b1, 0);
    rstn     = 1'b0;
    valid_in = 1'b1;
    sync_in  = 1'b0;
    din_real = lane_vec_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
    @(negedge clk);
    total++;
    if (valid_out !== 1'b0 || sync_err !== 1'b0 || base_idx_out !== '0) begin
      bad++;
      $display("FAIL rstmid_ctrl got v=%b se=%b base=%0d need 0/0/0", valid_out, sync_err, base_idx_out);
    end
    total++;
    if ({out_real_a, out_imag_a, out_real_b, out_imag_b} !== '0) begin
      bad++;
      $display("FAIL rstmid_data got ra=%h ib=%h need 0", out_real_a, out_imag_b);
    end
    rstn     = 1'b1;
    valid_in = 1'b0;
    gen_random();
    drive_frame(0, 31, 1'b0, 0);
    repeat (4) @(negedge clk);
    total++;
    if (got_q.size() != 24) begin
      bad++;
      $display("FAIL rstmid_count got=%0d need=24", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rstmid_pair%0d got cyc=%0d base=%0d ra=%h rb=%h need cyc=%0d base=%0d ra=%h rb=%h",
                 i, got_q[i].cyc, got_q[i].base, got_q[i].ra, got_q[i].rb,
                 exp_q[i].cyc, exp_q[i].base, exp_q[i].ra, exp_q[i].rb);
      end
    end
  endtask

  task automatic test_extremes();
    clear_q();
    for (int n = 0; n < FFT_N; n++) begin
      fr_re[n] = (n % 2 == 0) ? sample_t'(-512) : sample_t'(511);
      fr_im[n] = (n % 2 == 0) ? sample_t'(511)  : sample_t'(-512);
    end
    drive_frame(0, 31, 1'b1, 0);
    repeat (4) @(negedge clk);
    total++;
    if (got_q.size() != 16) begin
      bad++;
      $display("FAIL ext_count got=%0d need=16", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL ext_pair%0d got ra=%h ia=%h rb=%h ib=%h need ra=%h ia=%h rb=%h ib=%h",
                 i, got_q[i].ra, got_q[i].ia, got_q[i].rb, got_q[i].ib,
                 exp_q[i].ra, exp_q[i].ia, exp_q[i].rb, exp_q[i].ib);
      end
    end
  endtask

  initial begin
    rstn     = 1'b0;
    valid_in = 1'b0;
    sync_in  = 1'b0;
    din_real = '0;
    din_imag = '0;
    test_reset();
    test_ramp();
    test_back_to_back();
    test_gaps();
    test_sync();
    test_reset_midframe();
    test_extremes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft_pair_buffer.md
# fft_pair_buffer

Stream-side feeder for the first radix-2 butterfly stage of the 512-point FFT. It accepts natural-order samples at 16 lanes per beat, holds the first half-frame (samples 0..255) in a beat buffer, and pairs each second-half beat (samples 256..511) with the buffered beat 256 samples earlier. It presents the pairs as the butterfly's a/b operand vectors, with a valid strobe and the lane-0 sample index of the a vector.

## Interface
- DATA_W, 10, sample component width (signed, 2's complement)
- LANES, 16, samples per beat
- FFT_N, 512, frame length; HALF_BEATS = FFT_N/(2*LANES) = 16
- clk  in  1  sole clock, rising edge
- rstn  in  1  reset, synchronous, active-low
- valid_in  in  1  input beat present
- sync_in  in  1  qualified by valid_in; marks beat 0 of a frame
- din_real  in  [LANES] x DATA_W signed  real parts, lane j = sample 16*beat+j
- din_imag  in  [LANES] x DATA_W signed  imaginary parts
- valid_out  out  1  pair vector valid (one cycle per pair beat)
- base_idx_out  out  9  sample index of lane 0 of out_*_a (0,16,…,240)
- out_real_a / out_imag_a  out  [LANES] x DATA_W signed  first-half samples n
- out_real_b / out_imag_b  out  [LANES] x DATA_W signed  second-half samples n+256
- sync_err  out  1  one-cycle pulse: sync_in seen with beat counter ≠ 0

## Operation
- beat_cnt: 5 bits, 0..31. Increments only on valid_in and wraps 31→0. Holds when valid_in is low, so gaps of any length are legal.
- Phases are implied by beat_cnt[4]:
  - FILL (0..15): write din to buf[beat_cnt]. No output.
  - PAIR (16..31): read buf[beat_cnt-16] as a; the incoming beat is b. Register both. valid_out is set the next cycle. base_idx_out = (beat_cnt-16)*16.
- Sync handling:
  - valid_in & sync_in & beat_cnt==0 is normal.
  - valid_in & sync_in & beat_cnt≠0: pulse sync_err. Discard the partial frame. Treat the beat as beat 0: write buf[0], then beat_cnt=1. No output for the discarded frame's remaining pairs.
  - sync_in without valid_in is ignored.
- Frames need no sync; wrap 31→0 starts a new frame implicitly. Back-to-back frames are legal with no bubble. buf[k] of frame f+1 is written at beat k, strictly after frame f read it at beat 16+k.
- Data passes bit-exact: no arithmetic, no width change. The butterfly performs growth.
- Reset (rstn low at a rising edge): valid_out=0, sync_err=0, base_idx_out=0, all out_* = 0, beat_cnt=0. Buffer contents are not reset and are never read before being rewritten. A reset mid-frame drops the frame. The first beat after reset is beat 0, whether or not sync_in is asserted.

## Timing
- Latency: a PAIR beat accepted at edge t gives valid_out plus data/base_idx valid after edge t+1. valid_out is high for exactly one cycle per accepted PAIR beat.
- Outputs hold their last values when valid_out is low. Consumers must qualify on valid_out.
- Throughput: 1 beat/cycle sustained; 16 output vectors per 32 input beats.
- sync_err is registered and asserted 1 cycle after the offending beat.
- A buffer read and write in the same cycle never target the same address. Read-during-write behaviour is don't-care.

## Structure
- Package fft_pkg holds DATA_W, LANES, FFT_N, HALF_BEATS, the beat-counter width, and typedef sample_t (signed [DATA_W-1:0]) with lane-vector typedefs. These are shared with the butterfly stages.
- Sub-module fft_beat_ram: HALF_BEATS x (2*LANES*DATA_W) simple dual-port RAM with one write port, one read port, and combinational read. Implement it as a register array so it maps to distributed RAM.
- Top level holds the counter, sync check, and output registers.

## Test plan
- Ramp frame: sample n = (re=n mod 512 − 256, im=−re), 32 contiguous beats. Expect 16 valid_out. Beat k has base_idx_out=16k, a lane j = sample 16k+j, b lane j = sample 256+16k+j.
- Three back-to-back frames with distinct seeds. Expect 48 valid_out with no bubble between frames and no cross-frame mixing.
- Random valid_in gaps (~40% duty, gaps up to 7 cycles). Expect pairings identical to the gapless case, and valid_out only one cycle after PAIR beats.
- sync_in asserted at beat 20 of a frame. Expect a sync_err pulse, no further pairs from the old frame, and the new frame pairing correctly with base_idx_out starting at 0.
- rstn low for 1 cycle at beat 24. Expect all outputs 0 the next cycle. The following frame is treated from beat 0 and produces 16 correct pairs.
- Extremes: lanes alternating −512/+511 in real and imag. Expect exact passthrough on a and b with no sign or width corruption.
